// File: rtl/game_check.sv
// game_check: crash/score/game-state FSM for the flappy-bird style game (optional high score via GAME_CHECK_HIGH_SCORE_EN)
module game_check #(
   parameter int BIRD_W    = 34,
   parameter int BIRD_H    = 24,
   parameter int PIPE_W    = 52,
   parameter int GAP_H     = 150,
   parameter int FLOOR_Y   = 650,
   parameter int OVER_HOLD = 120
) (
   input  logic        clk,
   input  logic        RESET_N,
   input  logic        move,
   input  logic        start,
   input  logic [10:0] bird_x,
   input  logic [10:0] bird_y,
   input  logic [10:0] pipe_x,
   input  logic [10:0] gap_y,
   output logic        RESET_GAME,
   output logic        game_over,
   output logic [7:0]  score,
   output logic [1:0]  state,
   output logic [7:0]  high_score
);
   localparam int HW = $clog2(OVER_HOLD + 1);
   localparam logic [11:0] BW_C = 12'(BIRD_W);
   localparam logic [11:0] BH_C = 12'(BIRD_H);
   localparam logic [11:0] PW_C = 12'(PIPE_W);
   localparam logic [11:0] GH_C = 12'(GAP_H);
   localparam logic [11:0] FY_C = 12'(FLOOR_Y);
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_e;
   state_e          state_q, state_d;
   logic [7:0]      score_q, score_d;
   logic            passed_q, passed_d;
   logic            pulse_q, pulse_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [11:0]     bx, by, px, gy;
   logic            crash, cleared, ahead;
   assign bx = {1'b0, bird_x};
   assign by = {1'b0, bird_y};
   assign px = {1'b0, pipe_x};
   assign gy = {1'b0, gap_y};
   // collision and pipe-position predicates, all widened to 12 bits so nothing wraps
   always_comb begin
      crash   = (by + BH_C >= FY_C) || bird_y[10] ||
                ((bx + BW_C > px) && (bx < px + PW_C) && ((by < gy) || (by + BH_C > gy + GH_C)));
      cleared = px + PW_C < bx;
      ahead   = px > bx + BW_C;
   end
   // next-state: start only from IDLE, crash/score only on PLAY move ticks, hold countdown in OVER
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      passed_d = passed_q;
      hold_d   = hold_q;
      pulse_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d  = PLAY;
            score_d  = '0;
            passed_d = 1'b0;
            pulse_d  = 1'b1;
         end
         PLAY: if (move) begin
            if (crash) begin
               state_d = OVER;
               hold_d  = '0;
            end else if (cleared && !passed_q) begin
               score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               passed_d = 1'b1;
            end else if (ahead) begin
               passed_d = 1'b0;
            end
         end
         OVER: if (move) begin
            state_d = (hold_q == HW'(OVER_HOLD - 1)) ? IDLE : OVER;
            hold_d  = (hold_q == HW'(OVER_HOLD - 1)) ? '0 : hold_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state register with asynchronous abandon-the-run reset
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         score_q  <= '0;
         passed_q <= 1'b0;
         pulse_q  <= 1'b0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         passed_q <= passed_d;
         pulse_q  <= pulse_d;
         hold_q   <= hold_d;
      end
   end
   assign RESET_GAME = pulse_q;
   assign game_over  = (state_q == OVER);
   assign score      = score_q;
   assign state      = state_q;
`ifdef GAME_CHECK_HIGH_SCORE_EN
   logic [7:0] high_q;
   // best score captured on the crash edge; crash never changes score so score_q is final
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) high_q <= '0;
      else if (state_q == PLAY && state_d == OVER && score_q > high_q) high_q <= score_q;
   end
   assign high_score = high_q;
`else
   assign high_score = '0;
`endif
endmodule
